// File: rtl/pipe_addn_tree.sv
// Pipelined adder tree: sums NUM_IN operands of WIDTH bits over $clog2(NUM_IN) registered levels.
// Valid/ready on both sides with bubble-collapsing stalls; `PIPE_ADDN_SIGNED_EN selects signed operands.
module pipe_addn_tree #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [NUM_IN*WIDTH-1:0]              in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [WIDTH+$clog2(NUM_IN)-1:0]      out_sum
);

    localparam int LAT = $clog2(NUM_IN);
    localparam int SW  = WIDTH + LAT;
    localparam int NP  = 1 << LAT;

    logic [SW-1:0]  lvl0 [NP];
    logic [LAT:1]   vld_q;
    logic [LAT:1]   vld_d;
    logic [LAT:0]   vld_up;
    logic [LAT+1:1] rdy;

    // Missing tree inputs are zero in both builds; a zero partner makes an odd
    // leftover pass through its level unchanged.
    for (genvar i = 0; i < NP; i++) begin : g_ext
        if (i < NUM_IN) begin : g_op
`ifdef PIPE_ADDN_SIGNED_EN
            assign lvl0[i] = {{LAT{in_data[i*WIDTH+WIDTH-1]}}, in_data[i*WIDTH +: WIDTH]};
`else
            assign lvl0[i] = {{LAT{1'b0}}, in_data[i*WIDTH +: WIDTH]};
`endif
        end else begin : g_pad
            assign lvl0[i] = '0;
        end
    end

    assign rdy[LAT+1] = out_ready;
    for (genvar k = 1; k <= LAT; k++) begin : g_rdy
        assign rdy[k] = !vld_q[k] || rdy[k+1];
    end

    assign vld_up = {vld_q, in_valid};

    always_comb begin
        vld_d = vld_q;
        for (int k = 1; k <= LAT; k++) begin
            if (rdy[k]) begin
                vld_d[k] = vld_up[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Partial sums are held at SW bits; the upper bits of early levels are
    // pure extension and are never exceeded by the sums they carry.
    for (genvar k = 1; k <= LAT; k++) begin : g_lvl
        localparam int N = NP >> k;

        logic [SW-1:0] src   [2*N];
        logic [SW-1:0] sum_q [N];
        logic [SW-1:0] sum_d [N];

        if (k == 1) begin : g_src_in
            for (genvar i = 0; i < 2*N; i++) begin : g_s
                assign src[i] = lvl0[i];
            end
        end else begin : g_src_lvl
            for (genvar i = 0; i < 2*N; i++) begin : g_s
                assign src[i] = g_lvl[k-1].sum_q[i];
            end
        end

        always_comb begin
            for (int i = 0; i < N; i++) begin
                sum_d[i] = sum_q[i];
                if (rdy[k]) begin
                    sum_d[i] = src[2*i] + src[2*i+1];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < N; i++) begin
                    sum_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    sum_q[i] <= sum_d[i];
                end
            end
        end
    end

    assign in_ready  = rdy[1];
    assign out_valid = vld_q[LAT];
    assign out_sum   = g_lvl[LAT].sum_q[0];

endmodule

// File: tb/tb_pipe_addn_tree.sv
// Directed bench for pipe_addn_tree: a 4x16 instance and a 3x8 odd-count instance.
module tb_pipe_addn_tree;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_data;
    logic [17:0] out_sum;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [23:0] b_in_data;
    logic [9:0]  b_out_sum;

    int n_chk  = 0;
    int n_pass = 0;

    pipe_addn_tree #(.WIDTH(16), .NUM_IN(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
    );

    pipe_addn_tree #(.WIDTH(8), .NUM_IN(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put_a(input logic v, input logic [15:0] a, b, c, d);
        in_valid = v;
        in_data  = {d, c, b, a};
    endtask

    task automatic one_shot_a(input string tag, input logic [15:0] a, b, c, d, input logic [17:0] exp);
        @(negedge clk); put_a(1'b1, a, b, c, d);
        @(negedge clk); put_a(1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
        chk({tag, "_lat"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_v"}, out_valid, 1);
        chk({tag, "_sum"}, out_sum, exp);
        @(negedge clk);
        chk({tag, "_drop"}, out_valid, 0);
    endtask

    task automatic one_shot_b(input string tag, input logic [7:0] a, b, c, input logic [9:0] exp);
        @(negedge clk); b_in_valid = 1'b1; b_in_data = {c, b, a};
        @(negedge clk); b_in_valid = 1'b0; b_in_data = '0;
        chk({tag, "_lat"}, b_out_valid, 0);
        @(negedge clk);
        chk({tag, "_v"}, b_out_valid, 1);
        chk({tag, "_sum"}, b_out_sum, exp);
        @(negedge clk);
        chk({tag, "_drop"}, b_out_valid, 0);
    endtask

    initial begin
        int sent, got, stall;
        bit seen, stall_done;
        logic [17:0] held;

        out_ready   = 1'b1;
        b_out_ready = 1'b1;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        put_a(1'b1, 16'd1, 16'd2, 16'd3, 16'd4);

        // Reset held with in_valid high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_sum", out_sum, 0);
            chk("rst_in_ready", in_ready, 1);
        end
        chk("rst_b_out_valid", b_out_valid, 0);
        rst_n = 1'b1;

        // Vector 1,2,3,4 accepted at the first edge after release
        @(negedge clk); put_a(1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
        chk("single_lat", out_valid, 0);
        @(negedge clk);
        chk("single_v", out_valid, 1);
        chk("single_sum", out_sum, 18'd10);
        @(negedge clk);
        chk("single_drop", out_valid, 0);
        @(negedge clk);
        chk("single_once", out_valid, 0);

`ifdef PIPE_ADDN_SIGNED_EN
        one_shot_a("carry", 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 18'h00000);
`else
        one_shot_a("carry", 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 18'h10000);
`endif
        one_shot_a("allones", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 18'h3FFFC);

        // Backpressure: six vectors k,2k,3k,4k (sum 10k), 4-cycle stall after first result
        sent = 0; got = 0; stall = 0; seen = 0; stall_done = 0; held = '0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge clk);
            if (stall > 0) begin
                chk("bp_hold_v", out_valid, 1);
                chk("bp_hold_sum", out_sum, held);
            end else if (stall_done && got < 6) begin
                chk("bp_nogap", out_valid, 1);
            end
            if (out_valid && !seen) begin
                seen  = 1;
                stall = 4;
                held  = out_sum;
            end
            if (sent < 6)
                put_a(1'b1, 16'(sent+1), 16'(2*(sent+1)), 16'(3*(sent+1)), 16'(4*(sent+1)));
            else
                put_a(1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
            out_ready = (stall > 0) ? 1'b0 : 1'b1;
            if (stall > 0) begin
                stall--;
                if (stall == 0) stall_done = 1;
            end
            #1;
            if (!out_ready) chk("bp_in_ready", in_ready, 0);
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                chk("bp_sum", out_sum, 32'(10*(got+1)));
                got++;
            end
        end
        put_a(1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
        out_ready = 1'b1;
        chk("bp_sent", sent, 6);
        chk("bp_got", got, 6);
        @(negedge clk);
        chk("bp_empty", out_valid, 0);

        // Reset with two vectors in flight
        @(negedge clk); put_a(1'b1, 16'd10, 16'd10, 16'd10, 16'd10);
        @(negedge clk); put_a(1'b1, 16'd20, 16'd20, 16'd20, 16'd20);
        @(negedge clk); put_a(1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
        chk("mid_pre_v", out_valid, 1);
        chk("mid_pre_sum", out_sum, 18'd40);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_v", out_valid, 0);
        chk("mid_rst_sum", out_sum, 0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_gone", out_valid, 0);
        end
        one_shot_a("after_rst", 16'd7, 16'd7, 16'd7, 16'd7, 18'd28);

        // Odd operand count, WIDTH=8
        one_shot_b("odd_small", 8'd5, 8'd6, 8'd7, 10'd18);
`ifdef PIPE_ADDN_SIGNED_EN
        one_shot_b("odd_max", 8'd255, 8'd255, 8'd255, 10'h3FD);
`else
        one_shot_b("odd_max", 8'd255, 8'd255, 8'd255, 10'd765);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_addn_tree.md
Name: pipe_addn_tree

Overview:
- Parametrised, fully registered pipelined adder tree that sums NUM_IN operands of WIDTH bits.
- Next-generation replacement for the fixed three-operand latch pipeline adders in the testbench RTL set.
- Uses edge-triggered flops, valid/ready handshakes on both sides and bubble-collapsing stalls.
- Result is full precision; no wrap-around.

Parameters:
- WIDTH, 16: operand width in bits.
- NUM_IN, 4: number of operands; legal range 2..16, any integer.
- LAT (localparam), $clog2(NUM_IN): number of tree levels, which equals the pipeline latency.
- SW (localparam), WIDTH+$clog2(NUM_IN): output sum width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand vector valid.
- in_ready  out  1  block can accept operands this cycle.
- in_data  in  NUM_IN*WIDTH  packed operands; operand i is in_data[i*WIDTH +: WIDTH].
- out_valid  out  1  out_sum holds a valid result.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  SW  sum of one operand vector.

Behaviour:
- One clock domain. Reset is asynchronous, active-low, on rst_n.
- Reset values, applied immediately on rst_n low:
  - all stage valid bits = 0;
  - all stage data registers = 0;
  - out_valid = 0;
  - out_sum = 0.
- Structure:
  - Level k (1..LAT) pairwise-adds the ceil(n/2) partial sums of level k-1 into registers.
  - Each level widens by 1 bit, capped at SW.
  - An odd leftover operand at a level is passed through, extended to the new width.
  - Level 0 is the extended input operands, padded with zeros up to the next power of two.
  - Operand extension is zero-extension (see Optional Feature for signed mode).
- Handshake:
  - Transfer on the input side when in_valid && in_ready at the rising edge.
  - Transfer on the output side when out_valid && out_ready at the rising edge.
  - Each level k holds a valid bit v[k]. ready[k] = !v[k] || ready[k+1], with ready[LAT+1] = out_ready.
  - in_ready = ready[1]. It is combinational, with no path from in_valid.
  - Level k loads when ready[k]. Its new v[k] is the upstream valid (in_valid for k=1).
  - out_valid = v[LAT]; out_sum = data of level LAT.
- Latency and throughput:
  - With no stall, a vector accepted at edge t produces out_valid=1 at edge t+LAT-1 (visible after it) and is consumable at edge t+LAT.
  - Sustained throughput is 1 vector per cycle.
- Stall:
  - While out_valid && !out_ready, out_sum and out_valid hold stable.
  - Empty levels upstream of the stall keep filling (bubbles collapse).
  - in_ready drops only when all LAT levels are valid and out_ready = 0.
  - Capacity is LAT vectors. No drop, duplication or reordering.
- Data registers load only when their level loads. No toggling on invalid cycles is required, but it is permitted.
- Simultaneous input and output transfer when full: both occur and occupancy is unchanged.
- Reset mid-operation: all in-flight vectors are discarded, out_valid falls asynchronously, and none of those results is ever emitted after release.
- in_valid may be asserted in the first cycle after rst_n deasserts.
- Arithmetic: out_sum is exact. No overflow is possible at SW bits.

Optional Feature:
- Macro: PIPE_ADDN_SIGNED_EN.
- Defined: operands are two's complement. Level 0 sign-extends each operand to SW bits, and out_sum is a two's complement SW-bit result. Zero padding of missing tree inputs is unchanged.
- Not defined: operands are unsigned and zero-extended; out_sum is unsigned.
- Handshake, latency and capacity are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 → out_valid=0, out_sum=0, in_ready=1 throughout. First accepted vector after release produces exactly one result.
- Single vector, WIDTH=16, NUM_IN=4, out_ready=1: operands 1,2,3,4 accepted at edge t → out_valid=1 after edge t+1, out_sum=18'd10, then out_valid=0.
- Width and sign: operands 0xFFFF,0x0001,0,0 → unsigned build out_sum=18'h10000; PIPE_ADDN_SIGNED_EN build out_sum=18'h00000. Operands 0xFFFF×4 → 18'h3FFFC in both builds.
- Backpressure: stream 6 back-to-back vectors with sums 10,20,…,60, holding out_ready=0 for 4 cycles after the first result →
  - in_ready=0 once 2 vectors are held;
  - out_sum stable while stalled;
  - all 6 sums emitted in order with no gaps once out_ready=1.
- Reset mid-flight: 2 vectors in the pipe, pulse rst_n low for 1 cycle → out_valid=0 immediately, neither sum ever appears, a following vector 7,7,7,7 yields 28.
- Odd count, NUM_IN=3, WIDTH=8: operands 5,6,7 → LAT=2, SW=10, out_sum=10'd18. Operands 255,255,255 → 10'd765.
